// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential execute unit for the MIPS datapath. Takes the
//                3-bit ALU control code plus the register operands and shift
//                amount, and returns a registered result, zero flag and
//                signed-overflow flag under a start/done handshake.
//                Logic, ADD, SUB and SLT complete in one cycle. SRL shifts one
//                bit per cycle while busy is held high.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1      rising-edge clock
//    rst_n     in   1      synchronous active-low reset
//    start     in   1      request, accepted only while busy is low
//    op        in   3      operation code (see c_OP_* below)
//    a         in   WIDTH  operand A (rs)
//    b         in   WIDTH  operand B (rt or immediate)
//    shamt     in   5      shift amount for SRL
//    busy      out  1      high while an SRL is iterating
//    done      out  1      one-cycle pulse when result/flags are updated
//    result    out  WIDTH  registered result, held until next completion
//    zero      out  1      registered (result == 0)
//    overflow  out  1      registered signed-overflow flag (ADD/SUB only)
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    // ------------------------------------------------------------------
    // Operation codes
    // ------------------------------------------------------------------
    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SLT = 3'b011;
    localparam logic [2:0] c_OP_SUB = 3'b100;
    localparam logic [2:0] c_OP_SRL = 3'b101;
    localparam logic [2:0] c_OP_XOR = 3'b110;
    localparam logic [2:0] c_OP_NOR = 3'b111;

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_done;
    logic             r_busy;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [0:0]       w_state_nxt;
    logic             w_accept;
    logic             w_srl_iter;
    logic             w_shift_last;
    logic [WIDTH-1:0] w_shreg_nxt;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_lt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;

    logic             w_wr_result;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_ovf_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;
    logic             w_load_shift;

    // A request is only seen in IDLE; in SHIFT start is ignored entirely.
    assign w_accept     = start && (r_state == c_ST_IDLE);
    // SRL by zero has nothing to iterate and completes like a logic op.
    assign w_srl_iter   = (op == c_OP_SRL) && (shamt != 5'd0);
    assign w_shift_last = (r_state == c_ST_SHIFT) && (r_cnt == 5'd1);
    assign w_shreg_nxt  = r_shreg >> 1;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    assign w_sum  = a + b;
    assign w_diff = a - b;

    // Overflow when the operands' signs make the true result
    // representable-sign-wise but the WIDTH-bit result sign disagrees with a.
    assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
    assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    // Sign of a-b is wrong exactly when the subtraction overflowed, so
    // correcting it with the overflow bit gives a true signed less-than.
    assign w_lt = w_diff[WIDTH-1] ^ w_sub_ovf;

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (op)
            c_OP_AND: w_alu_res = a & b;
            c_OP_OR:  w_alu_res = a | b;
            c_OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = w_add_ovf;
            end
            c_OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
            c_OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = w_sub_ovf;
            end
            c_OP_SRL: w_alu_res = b >> shamt;
            c_OP_XOR: w_alu_res = a ^ b;
            c_OP_NOR: w_alu_res = ~(a | b);
            default:  w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && w_srl_iter) begin
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (r_cnt == 5'd1) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath control logic
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_result  = 1'b0;
        w_res_nxt    = r_result;
        w_ovf_nxt    = r_overflow;
        w_done_nxt   = 1'b0;
        w_load_shift = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_srl_iter) begin
                        w_load_shift = 1'b1;
                    end else begin
                        w_wr_result = 1'b1;
                        w_res_nxt   = w_alu_res;
                        w_ovf_nxt   = w_alu_ovf;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            c_ST_SHIFT: begin
                // The final step writes the value being shifted this cycle,
                // not the stale register content.
                if (w_shift_last) begin
                    w_wr_result = 1'b1;
                    w_res_nxt   = w_shreg_nxt;
                    w_ovf_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_wr_result = 1'b0;
            end
        endcase
        // Registering the next-state decode keeps busy a clean flop output
        // that drops in the same cycle done rises.
        w_busy_nxt = (w_state_nxt == c_ST_SHIFT);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_cnt      <= 5'd0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_busy <= w_busy_nxt;

            if (w_wr_result) begin
                r_result   <= w_res_nxt;
                r_zero     <= (w_res_nxt == '0);
                r_overflow <= w_ovf_nxt;
            end

            if (w_load_shift) begin
                r_shreg <= b;
                r_cnt   <= shamt;
            end else if (r_state == c_ST_SHIFT) begin
                r_shreg <= w_shreg_nxt;
                r_cnt   <= r_cnt - 5'd1;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign zero     = r_zero;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq. Directed corner cases plus
//                randomized operations compared against an arithmetic
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [4:0]    shamt;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          zero;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: signed arithmetic in 64 bits, overflow = out of range.
    task automatic ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [4:0] s, output logic [31:0] r, output logic ov);
        longint sx;
        longint sy;
        longint t;
        longint maxp;
        longint minn;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        maxp = 64'sd2147483647;
        minn = -maxp - 64'sd1;
        ov   = 1'b0;
        t    = 0;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: begin t = sx + sy; r = t[31:0]; ov = (t > maxp) || (t < minn); end
            3'd3: r = (sx < sy) ? 32'd1 : 32'd0;
            3'd4: begin t = sx - sy; r = t[31:0]; ov = (t > maxp) || (t < minn); end
            3'd5: r = y >> s;
            3'd6: r = x ^ y;
            default: r = ~(x | y);
        endcase
    endtask

    // Issue one request from idle, wait for completion and check everything.
    // Called and returns with time just after a rising edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] s, input bit poke_mid);
        logic [31:0] er;
        logic        ov;
        logic [31:0] prev;
        int          lat;
        int          bcnt;
        int          exp_lat;
        bit          got;
        ref_model(o, x, y, s, er, ov);
        exp_lat = (o == 3'd5 && s != 5'd0) ? int'(s) : 0;
        prev    = result;
        op = o; a = x; b = y; shamt = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: an in-flight SRL must not see these.
        op = 3'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
        lat = 0; bcnt = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
            if (poke_mid && i == 10) check("hold_mid_shift", result, prev);
            start = (poke_mid && i == 3) ? 1'b1 : 1'b0;
            if (poke_mid && i == 3) begin
                op = 3'd2; a = 32'h1234_5678; b = 32'h1111_1111;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("latency", lat, exp_lat);
        check("busy_cycles", bcnt, exp_lat);
        check("busy_at_done", 32'(busy), 32'd0);
        check("result", result, er);
        check("zero", 32'(zero), 32'(er == 32'd0));
        check("overflow", 32'(overflow), 32'(ov));
        @(posedge clk); #1;
        check("done_single_pulse", 32'(done), 32'd0);
        check("result_held", result, er);
    endtask

    initial begin
        int dcnt;
        logic [2:0] ro;
        logic [4:0] rs;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corners
        run_op(3'd2, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0);          // ADD overflow
        run_op(3'd4, 32'd5, 32'd5, 5'd0, 1'b0);                   // SUB -> zero
        run_op(3'd4, 32'h8000_0000, 32'h1, 5'd0, 1'b0);           // SUB overflow
        run_op(3'd3, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);           // SLT -1 < 1
        run_op(3'd3, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0, 1'b0);   // SLT with a-b overflow
        run_op(3'd5, 32'h0, 32'h8000_0000, 5'd31, 1'b1);          // SRL max, poked ADD ignored
        run_op(3'd5, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0);           // SRL by zero
        run_op(3'd5, 32'h0, 32'hDEAD_BEEF, 5'd1, 1'b0);           // SRL by one

        // Back-to-back single-cycle ops, start held through done cycles
        a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; op = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        check("b2b_and_done", 32'(done), 32'd1);
        check("b2b_and", result, 32'hF000_F000);
        op = 3'd1;
        @(posedge clk); #1;
        check("b2b_or_done", 32'(done), 32'd1);
        check("b2b_or", result, 32'hFFF0_FFF0);
        op = 3'd7;
        @(posedge clk); #1;
        check("b2b_nor_done", 32'(done), 32'd1);
        check("b2b_nor", result, 32'h000F_000F);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_done", 32'(done), 32'd0);

        // Reset in the middle of an SRL
        op = 3'd5; b = 32'hFFFF_FFFF; shamt = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_zero", 32'(zero), 32'd1);
        check("midrst_overflow", 32'(overflow), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) dcnt++;
            @(posedge clk); #1;
        end
        check("midrst_no_done", dcnt, 0);

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            ro = 3'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_op(ro, $urandom, $urandom, rs, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
